// File: rtl/uart_rx_datapath_ctl_if.sv
// Host-side bundle for the oversampling UART receiver.
// Serial line, sample tick and read handshake in; word and status flags out.
interface uart_rx_datapath_ctl_if #(
    parameter int WORD_SIZE = 8
);
    logic                 i_serial_in;
    logic                 i_sample_tick;
    logic                 i_read_ack;
    logic [WORD_SIZE-1:0] o_rcv_datareg;
    logic                 o_read_ready;
    logic                 o_overrun_err;
    logic                 o_framing_err;

    modport master (
        output i_serial_in,
        output i_sample_tick,
        output i_read_ack,
        input  o_rcv_datareg,
        input  o_read_ready,
        input  o_overrun_err,
        input  o_framing_err
    );

    modport slave (
        input  i_serial_in,
        input  i_sample_tick,
        input  i_read_ack,
        output o_rcv_datareg,
        output o_read_ready,
        output o_overrun_err,
        output o_framing_err
    );
endinterface

// File: rtl/uart_rx_datapath_ctl.sv
// Oversampling UART receiver: sync, start validation, mid-bit sampling,
// stop check and host handshake. Ports: i_clk, i_rst (sync, high), bus.
module uart_rx_datapath_ctl #(
    parameter int WORD_SIZE  = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    uart_rx_datapath_ctl_if.slave bus
);
    localparam int SCW = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(WORD_SIZE + 1);

    localparam logic [SCW-1:0] C_HALF  = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] C_LAST  = SCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] C_WORDS = BCW'(WORD_SIZE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [SCW-1:0]       r_sample_count;
    logic [SCW-1:0]       w_sample_nxt;
    logic [BCW-1:0]       r_bit_count;
    logic [BCW-1:0]       w_bit_nxt;
    logic [BCW-1:0]       w_bit_inc;
    logic                 w_shift;
    logic                 w_done;

    logic                 r_sync;
    logic                 r_line_s;
    logic [WORD_SIZE-1:0] r_shiftreg;
    logic [WORD_SIZE-1:0] r_datareg;
    logic                 r_ready;
    logic                 r_overrun;
    logic                 r_framing;

    assign w_bit_inc = r_bit_count + BCW'(1);

    // State and counters; a reset mid-frame drops the partial word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= IDLE;
            r_sample_count <= '0;
            r_bit_count    <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_sample_count <= w_sample_nxt;
            r_bit_count    <= w_bit_nxt;
        end
    end

    // Everything advances only on sample ticks.
    always_comb begin
        w_state_nxt  = r_state;
        w_sample_nxt = r_sample_count;
        w_bit_nxt    = r_bit_count;
        w_shift      = 1'b0;
        w_done       = 1'b0;
        if (bus.i_sample_tick) begin
            unique case (r_state)
                IDLE: begin
                    if (!r_line_s) begin
                        w_state_nxt  = START;
                        w_sample_nxt = '0;
                    end
                end
                START: begin
                    if (r_sample_count == C_HALF) begin
                        w_sample_nxt = '0;
                        if (!r_line_s) begin
                            w_state_nxt = DATA;
                            w_bit_nxt   = '0;
                        end else begin
                            // Glitch shorter than half a bit.
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_sample_nxt = r_sample_count + SCW'(1);
                    end
                end
                DATA: begin
                    if (r_sample_count == C_LAST) begin
                        w_shift      = 1'b1;
                        w_sample_nxt = '0;
                        w_bit_nxt    = w_bit_inc;
                        if (w_bit_inc == C_WORDS) begin
                            w_state_nxt = STOP;
                        end
                    end else begin
                        w_sample_nxt = r_sample_count + SCW'(1);
                    end
                end
                STOP: begin
                    if (r_sample_count == C_LAST) begin
                        // Leave at mid-stop so a back-to-back
                        // start edge is not missed.
                        w_done       = 1'b1;
                        w_sample_nxt = '0;
                        w_state_nxt  = IDLE;
                    end else begin
                        w_sample_nxt = r_sample_count + SCW'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Two-flop synchroniser; idles high so reset never fakes a start.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync   <= 1'b1;
            r_line_s <= 1'b1;
        end else begin
            r_sync   <= bus.i_serial_in;
            r_line_s <= r_sync;
        end
    end

    // LSB arrives first, so shift right and insert at the MSB.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shiftreg <= '0;
        end else if (w_shift) begin
            r_shiftreg <= {r_line_s, r_shiftreg[WORD_SIZE-1:1]};
        end
    end

    // Completion takes priority over a simultaneous acknowledge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_datareg <= '0;
            r_ready   <= 1'b0;
            r_overrun <= 1'b0;
            r_framing <= 1'b0;
        end else if (w_done) begin
            r_datareg <= r_shiftreg;
            r_ready   <= 1'b1;
            r_framing <= ~r_line_s;
            r_overrun <= r_ready & ~bus.i_read_ack;
        end else if (bus.i_read_ack && r_ready) begin
            r_ready   <= 1'b0;
            r_overrun <= 1'b0;
            r_framing <= 1'b0;
        end
    end

    assign bus.o_rcv_datareg = r_datareg;
    assign bus.o_read_ready  = r_ready;
    assign bus.o_overrun_err = r_overrun;
    assign bus.o_framing_err = r_framing;
endmodule

// File: doc/uart_rx_datapath_ctl.md
# uart_rx_datapath_ctl

Oversampling UART receiver: the receive-side counterpart of the UART transmit path in the simple_uart block. It synchronises the serial line, detects and validates the start bit, and samples each data bit at mid-bit. It assembles the data bits LSB first and checks the stop bit. It then presents the word to the host through a ready/acknowledge handshake with overrun and framing error flags. Frame format: one start bit (0), word_size data bits LSB first, one stop bit (1); the line idles at 1.

## Interface
- word_size, 8, data bits per frame
- oversample, 8, sample_tick pulses per bit period; must be even and ≥ 4
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- serial_in  in  1  asynchronous serial line
- sample_tick  in  1  one-clk enable pulse at oversample × baud rate
- read_ack  in  1  host consumes the current word (one-clk pulse)
- rcv_datareg  out  word_size  last received word
- read_ready  out  1  rcv_datareg holds an unconsumed word
- overrun_err  out  1  a new word overwrote an unconsumed word
- framing_err  out  1  stop bit of the last word sampled as 0

## Operation
- The serial_in line passes through a 2-flop synchroniser (line_s); both flops reset to 1. All sampling uses line_s and happens only on cycles where sample_tick=1.
- The counters are:
  - sample_count: $clog2(oversample) bits, wraps at oversample-1.
  - bit_count: $clog2(word_size+1) bits.
- The shift register rcv_shiftreg is word_size bits wide. Shifting is right with insertion at the MSB, {line_s, rcv_shiftreg[word_size-1:1]}, so the first data bit ends in bit 0.
- FSM state transitions:
  - IDLE: on a tick with line_s=0, go to START and clear sample_count.
  - START: each tick increments sample_count. On the tick where sample_count == oversample/2-1 (mid start bit), check line_s:
    - line_s=0: go to DATA and clear sample_count and bit_count.
    - line_s=1: false start; return to IDLE.
  - DATA: each tick increments sample_count. On the tick where sample_count == oversample-1, shift line_s in, clear sample_count, and increment bit_count. When the bit_count increment reaches word_size, go to STOP.
  - STOP: on the tick where sample_count == oversample-1, complete the frame and go to IDLE.
- Frame completion, in a single clk:
  - rcv_datareg ← rcv_shiftreg.
  - read_ready ← 1.
  - framing_err ← ~line_s.
  - overrun_err ← read_ready & ~read_ack (as seen before this cycle's update).
- Handshake:
  - read_ack=1 while read_ready=1 clears read_ready, overrun_err and framing_err on the next edge.
  - read_ack while read_ready=0 is ignored.
  - The error flags are otherwise sticky until acknowledged or overwritten by the next frame completion.
- Boundary conditions:
  - read_ack in the same cycle as frame completion: completion wins. read_ready stays 1, overrun_err=0, and framing_err reflects the new frame.
  - Framing error with the line still 0 after STOP: go to IDLE normally. A start is then detected on the next tick; no special recovery.
  - sample_tick=0: the FSM and all counters hold.
  - rst in any state: return to IDLE on the next edge and discard the partial frame.
- Reset values: state IDLE, counters 0, rcv_shiftreg 0, rcv_datareg 0, read_ready 0, overrun_err 0, framing_err 0, synchroniser 1.

## Timing
- The input synchroniser adds 2 clk of latency.
- A start bit is accepted oversample/2 ticks after the first low tick sampled in IDLE.
- Data bit k is sampled oversample·(k+1) ticks after start acceptance.
- The stop bit is sampled oversample·(word_size+1) ticks after start acceptance.
- read_ready, rcv_datareg and the error flags are registered and change on the clk edge that ends the stop-sample tick cycle.
- A frame therefore occupies oversample/2 + oversample·(word_size+1) ticks from detection to completion: 76 ticks with the defaults.
- Back-to-back frames (stop immediately followed by start) are supported, because the FSM returns to IDLE at mid-stop-bit.

## Test plan
- Reset values: assert rst for 2 clk with serial_in=1 -> all outputs 0, and no read_ready after 200 idle ticks.
- Basic receive: with sample_tick=1 every clk, drive frame 0xA5 (8 clk per bit) -> read_ready=1, rcv_datareg=8'hA5, both errors 0. Then read_ack pulse -> read_ready=0 on the next edge.
- False start: drive a 2-tick low glitch on an idle line -> FSM returns to IDLE and read_ready stays 0. A following valid 0x3C frame -> rcv_datareg=8'h3C.
- Framing error: drive 0x81 with stop bit 0 -> rcv_datareg=8'h81, read_ready=1, framing_err=1. A subsequent read_ack clears it.
- Overrun and simultaneous events:
  - 0x11 then 0x22 back-to-back with no read_ack -> rcv_datareg=8'h22, overrun_err=1.
  - Repeat with read_ack pulsed exactly on the 0x22 completion cycle -> overrun_err=0, read_ready=1.
- Reset mid-frame and tick gating:
  - Assert rst during data bit 3 of 0xFF -> no read_ready. The next 0x5A frame -> rcv_datareg=8'h5A.
  - Run at sample_tick every 4th clk -> identical results.
